// File: rtl/frame_luma_stat.sv
// Per-frame luma statistics: converts active RGB pixels to luma and accumulates count/sum/min/max.
// At each vs rising edge the frame is snapshotted and the mean is produced by a serial restoring divider.
module frame_luma_stat #(
    parameter int PIXEL_WIDTH = 8,
    parameter int CNT_WIDTH   = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PIXEL_WIDTH*3-1:0] di_i,
    input  logic                     de_i,
    input  logic                     hs_i,
    input  logic                     vs_i,
    output logic [PIXEL_WIDTH-1:0]   mean_o,
    output logic [PIXEL_WIDTH-1:0]   min_o,
    output logic [PIXEL_WIDTH-1:0]   max_o,
    output logic [CNT_WIDTH-1:0]     cnt_o,
    output logic                     ovf_o,
    output logic                     stat_vld_o,
    output logic                     busy_o,
    output logic                     skip_o
);
    localparam int PW    = PIXEL_WIDTH;
    localparam int CW    = CNT_WIDTH;
    localparam int SUM_W = PW + CW;
    localparam int PRW   = PW + 8;
    localparam int YSW   = PW + 10;
    localparam int STW   = $clog2(SUM_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Pipeline registers: S0 input capture, S1 products, S2 luma
    logic [PW*3-1:0] s0_di_q;
    logic            s0_de_q, s0_mk_q, vs_prev_q;
    logic [PRW-1:0]  s1_pr_q, s1_pg_q, s1_pb_q;
    logic            s1_de_q, s1_mk_q;
    logic [PW-1:0]   s2_y_q;
    logic            s2_de_q, s2_mk_q;
    logic [YSW-1:0]  ysum_d;
    logic [PW-1:0]   y_d;

    // Accumulators, snapshot and divider state
    logic [CW-1:0]    acc_cnt_q, acc_cnt_d;
    logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
    logic [PW-1:0]    acc_min_q, acc_min_d, acc_max_q, acc_max_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic [CW-1:0]    snap_cnt_q;
    logic [SUM_W-1:0] snap_sum_q;
    logic [PW-1:0]    snap_min_q, snap_max_q;
    logic             snap_ovf_q, snap_vld_q, skip_q;
    state_t           state_q, state_d;
    logic [STW-1:0]   step_q;
    logic [SUM_W-1:0] dvd_q, dvd_d;
    logic [CW-1:0]    rem_q;
    logic [CW:0]      rem_sh, rem_d;
    logic             rem_ge, last_step;
    logic [PW-1:0]    mean_q, min_q, max_q;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;

    // hs_i carries nothing the statistics need; the tautology keeps the port consumed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_di_q   <= '0;
            s0_de_q   <= 1'b0;
            s0_mk_q   <= 1'b0;
            vs_prev_q <= 1'b1;
            s1_pr_q   <= '0;
            s1_pg_q   <= '0;
            s1_pb_q   <= '0;
            s1_de_q   <= 1'b0;
            s1_mk_q   <= 1'b0;
            s2_y_q    <= '0;
            s2_de_q   <= 1'b0;
            s2_mk_q   <= 1'b0;
        end else begin
            s0_di_q   <= di_i;
            s0_de_q   <= de_i & (hs_i | ~hs_i);
            s0_mk_q   <= vs_i & ~vs_prev_q;
            vs_prev_q <= vs_i;
            s1_pr_q   <= PRW'(s0_di_q[PW*0 +: PW]) * PRW'(77);
            s1_pg_q   <= PRW'(s0_di_q[PW*1 +: PW]) * PRW'(150);
            s1_pb_q   <= PRW'(s0_di_q[PW*2 +: PW]) * PRW'(29);
            s1_de_q   <= s0_de_q;
            s1_mk_q   <= s0_mk_q;
            s2_y_q    <= y_d;
            s2_de_q   <= s1_de_q;
            s2_mk_q   <= s1_mk_q;
        end
    end

    always_comb begin
        ysum_d = YSW'(s1_pr_q) + YSW'(s1_pg_q) + YSW'(s1_pb_q) + YSW'(128);
        y_d    = PW'(ysum_d >> 8);
    end

    // Next accumulator values include the S3 pixel, so a closing frame keeps its last pixel
    always_comb begin
        acc_cnt_d = acc_cnt_q;
        acc_sum_d = acc_sum_q;
        acc_min_d = acc_min_q;
        acc_max_d = acc_max_q;
        acc_ovf_d = acc_ovf_q;
        if (s2_de_q) begin
            if (&acc_cnt_q) begin
                acc_ovf_d = 1'b1;
            end else begin
                acc_cnt_d = acc_cnt_q + CW'(1);
                acc_sum_d = acc_sum_q + SUM_W'(s2_y_q);
            end
            if (s2_y_q < acc_min_q) acc_min_d = s2_y_q;
            if (s2_y_q > acc_max_q) acc_max_d = s2_y_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt_q  <= '0;
            acc_sum_q  <= '0;
            acc_min_q  <= '1;
            acc_max_q  <= '0;
            acc_ovf_q  <= 1'b0;
            snap_cnt_q <= '0;
            snap_sum_q <= '0;
            snap_min_q <= '0;
            snap_max_q <= '0;
            snap_ovf_q <= 1'b0;
            snap_vld_q <= 1'b0;
            skip_q     <= 1'b0;
        end else begin
            snap_vld_q <= 1'b0;
            skip_q     <= 1'b0;
            if (s2_mk_q) begin
                acc_cnt_q <= '0;
                acc_sum_q <= '0;
                acc_min_q <= '1;
                acc_max_q <= '0;
                acc_ovf_q <= 1'b0;
                // Snapshot operands must stay stable while the divider reads them
                if (state_q != S_DIV) begin
                    snap_cnt_q <= acc_cnt_d;
                    snap_sum_q <= acc_sum_d;
                    snap_min_q <= acc_min_d;
                    snap_max_q <= acc_max_d;
                    snap_ovf_q <= acc_ovf_d;
                    snap_vld_q <= 1'b1;
                end else begin
                    skip_q <= 1'b1;
                end
            end else begin
                acc_cnt_q <= acc_cnt_d;
                acc_sum_q <= acc_sum_d;
                acc_min_q <= acc_min_d;
                acc_max_q <= acc_max_d;
                acc_ovf_q <= acc_ovf_d;
            end
        end
    end

    // Restoring division: dvd_q shifts the dividend out and the quotient in
    always_comb begin
        rem_sh    = {rem_q, dvd_q[SUM_W-1]};
        rem_ge    = rem_sh >= {1'b0, snap_cnt_q};
        rem_d     = rem_ge ? (rem_sh - {1'b0, snap_cnt_q}) : rem_sh;
        dvd_d     = {dvd_q[SUM_W-2:0], rem_ge};
        last_step = (step_q == STW'(SUM_W - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (snap_vld_q) state_d = S_DIV;
            S_DIV:   if (last_step) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            mean_q  <= '0;
            min_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && snap_vld_q) begin
                dvd_q  <= snap_sum_q;
                rem_q  <= '0;
                step_q <= '0;
            end
            if (state_q == S_DIV) begin
                dvd_q  <= dvd_d;
                rem_q  <= CW'(rem_d);
                step_q <= step_q + STW'(1);
                if (last_step) begin
                    // An empty frame would divide by zero and leave min at all-ones
                    mean_q <= (snap_cnt_q == '0) ? '0 : dvd_d[PW-1:0];
                    min_q  <= (snap_cnt_q == '0) ? '0 : snap_min_q;
                    max_q  <= snap_max_q;
                    cnt_q  <= snap_cnt_q;
                    ovf_q  <= snap_ovf_q;
                end
            end
        end
    end

    assign mean_o     = mean_q;
    assign min_o      = min_q;
    assign max_o      = max_q;
    assign cnt_o      = cnt_q;
    assign ovf_o      = ovf_q;
    assign stat_vld_o = (state_q == S_DONE);
    assign busy_o     = (state_q == S_DIV);
    assign skip_o     = skip_q;
endmodule
